// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants (reset PC, NOP encoding) and the buffered instruction entry type
package riscv_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO (clk, rst, flush clears; push/din write; pop advances; head/count/empty from registers)
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC + imem req/gnt/rvalid master, buffered {pc,instr} toward decode (valid/ready), redirect flush
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] fetch_pc, tag_pc;
  logic [CW-1:0] in_flight, in_flight_next, discard, fifo_count;
  logic gnt_hs, rsp, push, pop, empty, tag_empty;
  if_entry_t head;
  assign imem_req_o = !rst_i && !redirect_i &&
                      ({1'b0, in_flight} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;
  assign gnt_hs = imem_req_o && imem_gnt_i;
  assign rsp = imem_rvalid_i && !tag_empty;
  assign in_flight_next = in_flight + CW'(gnt_hs) - CW'(rsp);
  assign push = rsp && discard == '0 && !redirect_i;
  assign pop = instr_valid_o && instr_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      discard <= '0;
    end else begin
      fetch_pc <= redirect_i ? (redirect_pc_i & ~32'd3) : gnt_hs ? fetch_pc + 32'd4 : fetch_pc;
      discard <= redirect_i ? in_flight_next : (rsp && discard != '0) ? discard - CW'(1) : discard;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_q (
    .clk(clk_i), .rst(rst_i), .flush(1'b0), .push(gnt_hs), .din(fetch_pc),
    .pop(rsp), .head(tag_pc), .count(in_flight), .empty(tag_empty)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(if_entry_t))) u_instr_q (
    .clk(clk_i), .rst(rst_i), .flush(redirect_i), .push(push), .din({tag_pc, imem_rdata_i}),
    .pop(pop), .head(head), .count(fifo_count), .empty(empty)
  );
  assign instr_valid_o = !empty;
  assign instr_o = empty ? NOP_INSTR : head.instr;
  assign instr_pc_o = empty ? 32'd0 : head.pc;
endmodule
